// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, divider floor, and the CTRL/register
// indices used by the uart_module register block.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_e;

    localparam int unsigned CLK_DIV_MIN = 4;

    // CTRL register bit positions
    localparam int CTRL_TX_EN   = 0;
    localparam int CTRL_TX_FULL = 1;
    localparam int CTRL_RX_FULL = 2;
    localparam int CTRL_RX_ERR  = 3;

    // Register indices in the uart_module map
    localparam int REG_DATA    = 0;
    localparam int REG_CTRL    = 1;
    localparam int REG_CLK_DIV = 2;

    function automatic logic [31:0] clamp_div(input logic [31:0] div);
        return (div < 32'(CLK_DIV_MIN)) ? 32'(CLK_DIV_MIN) : div;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for an asynchronous input that idles high; resets to 1 so
// that leaving reset never looks like a falling edge.
module uart_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rstn_i,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge value of its neighbour, exactly like the hardware chain.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) ff <= '1;
        else         ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_rx_sampler.sv
// UART receive sampler: synchronizes rx_i, mid-bit samples 8N(P)1 frames and emits
// each byte with a single-cycle valid pulse and a parity/framing error flag.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter bit PARITY_EN   = 1'b1,
    parameter bit PARITY_ODD  = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rstn_i,
    input  logic [31:0] clk_div_i,
    input  logic        rx_i,
    output logic [7:0]  rx_data_o,
    output logic        rx_valid_o,
    output logic        rx_err_o
);

    rx_state_e   state_q, state_d;
    logic [31:0] baud_q, baud_d;
    logic [31:0] div_q, div_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        par_err_q, par_err_d;
    logic [7:0]  data_d;
    logic        err_d, valid_d;
    logic        rx_s;
    logic        tick;
    logic [31:0] div_in;

    uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .rstn_i (rstn_i),
        .d      (rx_i),
        .q      (rx_s)
    );

    assign div_in = clamp_div(clk_div_i);
    assign tick   = (baud_q == 32'd0);

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            div_q      <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
            par_err_q  <= 1'b0;
            rx_data_o  <= '0;
            rx_err_o   <= 1'b0;
            rx_valid_o <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            par_err_q  <= par_err_d;
            rx_data_o  <= data_d;
            rx_err_o   <= err_d;
            rx_valid_o <= valid_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        div_d     = div_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        par_err_d = par_err_q;
        data_d    = rx_data_o;
        err_d     = rx_err_o;
        valid_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d   = START;
                    div_d     = div_in;
                    baud_d    = (div_in >> 1) - 32'd1;
                    par_err_d = 1'b0;
                end
            end
            START: begin
                if (!tick) begin
                    baud_d = baud_q - 32'd1;
                end else if (rx_s) begin
                    state_d = IDLE;          // line bounced back high: glitch, not a start bit
                end else begin
                    state_d = DATA;
                    baud_d  = div_q - 32'd1;
                    bit_d   = 3'd0;
                end
            end
            DATA: begin
                if (!tick) begin
                    baud_d = baud_q - 32'd1;
                end else begin
                    shreg_d[bit_q] = rx_s;
                    bit_d          = bit_q + 3'd1;
                    baud_d         = div_q - 32'd1;
                    if (bit_q == 3'd7) state_d = PARITY_EN ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (!tick) begin
                    baud_d = baud_q - 32'd1;
                end else begin
                    par_err_d = ((^shreg_q) ^ rx_s) != PARITY_ODD;
                    baud_d    = div_q - 32'd1;
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (!tick) begin
                    baud_d = baud_q - 32'd1;
                end else begin
                    // Re-arm at mid-stop so a back-to-back start edge is not missed.
                    data_d  = shreg_q;
                    err_d   = par_err_q | ~rx_s;
                    valid_d = 1'b1;
                    state_d = rx_s ? IDLE : BREAK;
                end
            end
            BREAK: begin
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Self-checking bench: drives serial frames into even- and odd-parity receivers and
// compares every received byte against a frame-level reference model.
module tb_uart_rx_sampler;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] clk_div;
    logic        rx;
    logic [7:0]  data_e, data_o;
    logic        valid_e, valid_o, err_e, err_o;

    int total = 0;
    int bad   = 0;

    logic [8:0] got_e[$], got_o[$], exp_e[$], exp_o[$];
    int   dbl_e  = 0, dbl_o = 0;
    logic prev_e = 1'b0, prev_o = 1'b0;

    always #5 clk = ~clk;

    uart_rx_sampler #(.PARITY_EN(1'b1), .PARITY_ODD(1'b0), .SYNC_STAGES(2)) dut_even (
        .clk(clk), .rstn_i(rstn), .clk_div_i(clk_div), .rx_i(rx),
        .rx_data_o(data_e), .rx_valid_o(valid_e), .rx_err_o(err_e)
    );

    uart_rx_sampler #(.PARITY_EN(1'b1), .PARITY_ODD(1'b1), .SYNC_STAGES(2)) dut_odd (
        .clk(clk), .rstn_i(rstn), .clk_div_i(clk_div), .rx_i(rx),
        .rx_data_o(data_o), .rx_valid_o(valid_o), .rx_err_o(err_o)
    );

    // Collect every delivered byte and watch for back-to-back valid pulses.
    always @(negedge clk) begin
        if (valid_e) got_e.push_back({err_e, data_e});
        if (valid_o) got_o.push_back({err_o, data_o});
        if (valid_e && prev_e) dbl_e++;
        if (valid_o && prev_o) dbl_o++;
        prev_e = valid_e;
        prev_o = valid_o;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int eff_div(input logic [31:0] div);
        return (div < 32'd4) ? 4 : int'(div);
    endfunction

    task automatic hold_line(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    // Drive one frame and record what each receiver must report for it.
    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop,
                              input logic [31:0] div);
        int n;
        int ones;
        n       = eff_div(div);
        clk_div = div;
        hold_line(1'b0, n);
        clk_div = $urandom;              // mid-frame divider changes must be ignored
        for (int i = 0; i < 8; i++) hold_line(d[i], n);
        hold_line(pbit, n);
        hold_line(stop, n);
        ones = $countones(d) + int'(pbit);
        exp_e.push_back({((ones % 2) != 0) || !stop, d});
        exp_o.push_back({((ones % 2) != 1) || !stop, d});
    endtask

    task automatic compare_step(input string tag);
        check({tag, " count even"}, 32'(got_e.size()), 32'(exp_e.size()));
        check({tag, " count odd"},  32'(got_o.size()), 32'(exp_o.size()));
        for (int i = 0; i < exp_e.size(); i++)
            if (i < got_e.size()) check({tag, " byte even"}, 32'(got_e[i]), 32'(exp_e[i]));
        for (int i = 0; i < exp_o.size(); i++)
            if (i < got_o.size()) check({tag, " byte odd"}, 32'(got_o[i]), 32'(exp_o[i]));
        got_e.delete(); got_o.delete(); exp_e.delete(); exp_o.delete();
    endtask

    initial begin
        int dv;
        logic [7:0] rd;
        logic [31:0] last_div [3];

        rstn    = 1'b0;
        rx      = 1'b1;
        clk_div = 32'd16;
        repeat (3) @(negedge clk);
        check("reset data even",  32'(data_e),  32'h0);
        check("reset valid even", 32'(valid_e), 32'h0);
        check("reset err even",   32'(err_e),   32'h0);
        check("reset data odd",   32'(data_o),  32'h0);
        check("reset valid odd",  32'(valid_o), 32'h0);
        check("reset err odd",    32'(err_o),   32'h0);
        rstn = 1'b1;
        hold_line(1'b1, 32);

        // Clean frame with correct even parity
        send_frame(8'hA5, 1'b0, 1'b1, 32'd16);
        hold_line(1'b1, 32);
        compare_step("t1 A5");
        check("t1 hold data", 32'(data_e), 32'hA5);

        // Wrong even parity, right odd parity
        send_frame(8'h3C, 1'b1, 1'b1, 32'd16);
        hold_line(1'b1, 32);
        compare_step("t2 3C");

        // Short low glitch must be rejected, then a real frame
        clk_div = 32'd16;
        hold_line(1'b0, 5);
        hold_line(1'b1, 48);
        compare_step("t3 glitch");
        send_frame(8'h55, 1'b0, 1'b1, 32'd16);
        hold_line(1'b1, 32);
        compare_step("t3 55");

        // Line held low 20 bit times: one framing-error byte, then silence
        send_frame(8'h00, 1'b0, 1'b0, 32'd16);
        hold_line(1'b0, 9 * 16);
        hold_line(1'b1, 32);
        compare_step("t4 break");
        send_frame(8'h81, 1'b0, 1'b1, 32'd16);
        hold_line(1'b1, 32);
        compare_step("t4 81");

        // Back-to-back frames, no idle, across divider extremes and the clamp
        last_div = '{32'd4, 32'd1000, 32'd0};
        foreach (last_div[k]) begin
            send_frame(8'h00, 1'b0, 1'b1, last_div[k]);
            send_frame(8'hFF, 1'b0, 1'b1, last_div[k]);
            send_frame(8'h7E, 1'b0, 1'b1, last_div[k]);
            hold_line(1'b1, 2 * eff_div(last_div[k]));
            compare_step($sformatf("t5 div%0d", last_div[k]));
        end

        // Reset in the middle of data bit 4 of a 0xC3 frame
        clk_div = 32'd16;
        hold_line(1'b0, 16);
        hold_line(1'b1, 16);
        hold_line(1'b1, 16);
        hold_line(1'b0, 16);
        hold_line(1'b0, 16);
        hold_line(1'b0, 8);
        rstn = 1'b0;
        #1;
        check("t6 data after reset",  32'(data_e),  32'h0);
        check("t6 valid after reset", 32'(valid_e), 32'h0);
        check("t6 err after reset",   32'(err_o),   32'h0);
        hold_line(1'b1, 16);
        rstn = 1'b1;
        hold_line(1'b1, 48);
        compare_step("t6 aborted");
        send_frame(8'hC3, 1'b0, 1'b1, 32'd16);
        hold_line(1'b1, 32);
        compare_step("t6 C3");

        // Random bytes, parity bits, dividers and idle gaps
        for (int f = 0; f < 12; f++) begin
            rd = 8'($urandom);
            dv = int'($urandom_range(0, 24));
            send_frame(rd, 1'($urandom_range(0, 1)), 1'b1, 32'(dv));
            hold_line(1'b1, int'($urandom_range(0, 2)) * eff_div(32'(dv)));
        end
        hold_line(1'b1, 64);
        compare_step("random");

        check("no double valid even", 32'(dbl_e), 32'h0);
        check("no double valid odd",  32'(dbl_o), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
